// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and helpers for the MEM pipeline stage:
//                access size / FSM state enums, byte-enable constants,
//                alignment check and store lane steering.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  localparam logic [3:0] c_BE_BYTE = 4'b0001;
  localparam logic [3:0] c_BE_HALF = 4'b0011;
  localparam logic [3:0] c_BE_WORD = 4'b1111;

  // Size code 2'b11 is treated as a word everywhere (falls into default).
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: byte_enables = c_BE_BYTE << addr_lo;
      SZ_HALF: byte_enables = c_BE_HALF << addr_lo;
      default: byte_enables = c_BE_WORD;
    endcase
  endfunction

  // Replicate store data across all lanes; the byte enables pick the lane.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_lanes = {4{wd[7:0]}};
      SZ_HALF: store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load data alignment. Shifts the addressed
//                byte/half down to bit 0 and sign- or zero-extends it.
//  Ports       : rdata       in  32  raw word from data memory
//                addr_lo     in  2   byte offset within the word
//                size        in  2   access size (mem_size_t coding)
//                is_unsigned in  1   1 = zero-extend
//                load_val    out 32  value for the register file
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_val
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_BYTE: load_val = {{24{~is_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: load_val = {{16{~is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: load_val = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM pipeline stage. Consumes the EX/MEM latch, runs data
//                memory loads/stores over a req/ack handshake with variable
//                latency and an optional timeout, stalls upstream while the
//                access is outstanding, and drives the MEM/WB register.
//                Branch resolution is passed straight through.
//  Ports       : clk, reset (sync, active-high)
//                EX/MEM inputs : valid_M zero_M aluresult_M writedata_M
//                                writereg_M pcbranch_M regwrite_M memtoreg_M
//                                memread_M memwrite_M branch_M size_M unsigned_M
//                Data memory   : dmem_req/we/addr/wdata/be out, dmem_ack/rdata in
//                Pipeline ctrl : stall_M pcsrc_M pcbranch_out misalign_M bus_err
//                MEM/WB        : valid_W regwrite_W memtoreg_W aluresult_W
//                                readdata_W writereg_W
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_M,
  input  logic             zero_M,
  input  logic [31:0]      aluresult_M,
  input  logic [31:0]      writedata_M,
  input  logic [REG_W-1:0] writereg_M,
  input  logic [31:0]      pcbranch_M,
  input  logic             regwrite_M,
  input  logic             memtoreg_M,
  input  logic             memread_M,
  input  logic             memwrite_M,
  input  logic             branch_M,
  input  logic [1:0]       size_M,
  input  logic             unsigned_M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [31:0]      dmem_rdata,
  output logic             stall_M,
  output logic             pcsrc_M,
  output logic [31:0]      pcbranch_out,
  output logic             misalign_M,
  output logic             bus_err,
  output logic             valid_W,
  output logic             regwrite_W,
  output logic             memtoreg_W,
  output logic [31:0]      aluresult_W,
  output logic [31:0]      readdata_W,
  output logic [REG_W-1:0] writereg_W
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  mem_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  // Request captured on entry to ACCESS; held stable until ack/timeout.
  logic [31:0]      r_acc_addr;
  logic [31:0]      r_acc_wdata;
  logic [3:0]       r_acc_be;
  logic [1:0]       r_acc_size;
  logic             r_acc_we, r_acc_uns, r_acc_regwrite, r_acc_memtoreg;
  logic [REG_W-1:0] r_acc_writereg;

  logic             w_memop, w_latch, w_timeout;
  logic [31:0]      w_load_val;

  logic             w_valid_nxt, w_regwrite_nxt, w_memtoreg_nxt;
  logic [31:0]      w_alu_nxt, w_rd_nxt;
  logic [REG_W-1:0] w_wreg_nxt;

  load_align u_load_align (
    .rdata       (dmem_rdata),
    .addr_lo     (r_acc_addr[1:0]),
    .size        (r_acc_size),
    .is_unsigned (r_acc_uns),
    .load_val    (w_load_val)
  );

  assign w_memop   = valid_M & (memread_M | memwrite_M);
  // r_cnt holds the 1-based index of the current ACCESS cycle.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

  assign pcsrc_M      = valid_M & branch_M & zero_M;
  assign pcbranch_out = pcbranch_M;
  assign dmem_req     = (r_state == ACCESS);
  assign dmem_we      = r_acc_we;
  assign dmem_addr    = {r_acc_addr[31:2], 2'b00};
  assign dmem_wdata   = r_acc_wdata;
  assign dmem_be      = r_acc_be;

  always_comb begin
    w_state_nxt    = r_state;
    stall_M        = 1'b0;
    misalign_M     = 1'b0;
    bus_err        = 1'b0;
    w_latch        = 1'b0;
    // MEM/WB defaults to a bubble; only retiring instructions overwrite it.
    w_valid_nxt    = 1'b0;
    w_regwrite_nxt = 1'b0;
    w_memtoreg_nxt = 1'b0;
    w_alu_nxt      = '0;
    w_rd_nxt       = '0;
    w_wreg_nxt     = '0;
    case (r_state)
      IDLE: begin
        if (!w_memop) begin
          w_valid_nxt    = valid_M;
          w_regwrite_nxt = regwrite_M;
          w_memtoreg_nxt = memtoreg_M;
          w_alu_nxt      = aluresult_M;
          w_wreg_nxt     = writereg_M;
        end else if (is_aligned(size_M, aluresult_M[1:0])) begin
          stall_M     = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          misalign_M = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          w_valid_nxt    = 1'b1;
          w_regwrite_nxt = r_acc_regwrite;
          w_memtoreg_nxt = r_acc_memtoreg;
          w_alu_nxt      = r_acc_addr;
          w_rd_nxt       = r_acc_we ? 32'd0 : w_load_val;
          w_wreg_nxt     = r_acc_writereg;
          w_state_nxt    = IDLE;
        end else if (w_timeout) begin
          // Release upstream so the faulting instruction leaves as a bubble.
          bus_err     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          stall_M = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_acc_addr     <= '0;
      r_acc_wdata    <= '0;
      r_acc_be       <= '0;
      r_acc_size     <= '0;
      r_acc_we       <= 1'b0;
      r_acc_uns      <= 1'b0;
      r_acc_regwrite <= 1'b0;
      r_acc_memtoreg <= 1'b0;
      r_acc_writereg <= '0;
      valid_W        <= 1'b0;
      regwrite_W     <= 1'b0;
      memtoreg_W     <= 1'b0;
      aluresult_W    <= '0;
      readdata_W     <= '0;
      writereg_W     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      valid_W     <= w_valid_nxt;
      regwrite_W  <= w_regwrite_nxt;
      memtoreg_W  <= w_memtoreg_nxt;
      aluresult_W <= w_alu_nxt;
      readdata_W  <= w_rd_nxt;
      writereg_W  <= w_wreg_nxt;
      if (w_latch) begin
        r_cnt          <= CNT_W'(1);
        r_acc_addr     <= aluresult_M;
        r_acc_wdata    <= store_lanes(size_M, writedata_M);
        r_acc_be       <= byte_enables(size_M, aluresult_M[1:0]);
        r_acc_size     <= size_M;
        r_acc_we       <= memwrite_M;
        r_acc_uns      <= unsigned_M;
        r_acc_regwrite <= regwrite_M;
        r_acc_memtoreg <= memtoreg_M;
        r_acc_writereg <= writereg_M;
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Self-checking bench for mem_stage_ctrl. A transaction-level
//                model predicts every output each cycle; directed cases pin
//                literal results, then randomized instructions follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int REG_W   = 5;
  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic             valid, zero, regwrite, memtoreg, memread, memwrite, branch, uns;
    logic [1:0]       size;
    logic [31:0]      alu, wd, pcb;
    logic [REG_W-1:0] wreg;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_M = 0, zero_M = 0, regwrite_M = 0, memtoreg_M = 0;
  logic memread_M = 0, memwrite_M = 0, branch_M = 0, unsigned_M = 0;
  logic [31:0] aluresult_M = 0, writedata_M = 0, pcbranch_M = 0;
  logic [REG_W-1:0] writereg_M = 0;
  logic [1:0] size_M = 0;
  logic dmem_ack = 0;
  logic [31:0] dmem_rdata = 0;

  logic dmem_req, dmem_we, stall_M, pcsrc_M, misalign_M, bus_err;
  logic valid_W, regwrite_W, memtoreg_W;
  logic [31:0] dmem_addr, dmem_wdata, pcbranch_out, aluresult_W, readdata_W;
  logic [3:0] dmem_be;
  logic [REG_W-1:0] writereg_W;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .zero_M(zero_M),
    .aluresult_M(aluresult_M), .writedata_M(writedata_M), .writereg_M(writereg_M),
    .pcbranch_M(pcbranch_M), .regwrite_M(regwrite_M), .memtoreg_M(memtoreg_M),
    .memread_M(memread_M), .memwrite_M(memwrite_M), .branch_M(branch_M),
    .size_M(size_M), .unsigned_M(unsigned_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_M(stall_M), .pcsrc_M(pcsrc_M),
    .pcbranch_out(pcbranch_out), .misalign_M(misalign_M), .bus_err(bus_err),
    .valid_W(valid_W), .regwrite_W(regwrite_W), .memtoreg_W(memtoreg_W),
    .aluresult_W(aluresult_W), .readdata_W(readdata_W), .writereg_W(writereg_W)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (from the rules, not the RTL) -------
  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] s, input logic uns);
    logic [31:0] v;
    v = rd >> (8 * a);
    if (nbytes(s) == 1) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (nbytes(s) == 2) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [1:0] a);
    int unsigned n;
    n = nbytes(s);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] wd);
    if (nbytes(s) == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (nbytes(s) == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  logic   m_busy = 1'b0;      // an access is outstanding
  int     m_waited = 0;       // ACCESS cycles already spent without ack
  logic   m_adv = 1'b1;       // last edge moved the EX/MEM instruction on
  instr_t m_t = '0;
  logic w_valid = 0, w_regwrite = 0, w_memtoreg = 0;
  logic [31:0] w_alu = 0, w_rd = 0;
  logic [REG_W-1:0] w_wreg = 0;
  logic e_stall = 0, e_mis = 0, e_berr = 0;
  logic started = 1'b0;
  int n_req = 0, n_mis = 0, n_berr = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic [3:0] last_be = 0;
  logic last_we = 0;

  task automatic wb_bubble();
    w_valid = 0; w_regwrite = 0; w_memtoreg = 0; w_alu = 0; w_rd = 0; w_wreg = 0;
  endtask

  // Compare process: expected outputs for the current cycle, checked mid-cycle.
  always @(negedge clk) begin : compare
    logic memop, al, last;
    memop  = valid_M && (memread_M || memwrite_M);
    al     = (aluresult_M % nbytes(size_M)) == 0;
    last   = m_busy && (TIMEOUT != 0) && (m_waited + 1 == TIMEOUT);
    e_stall = m_busy ? (!dmem_ack && !last) : (memop && al);
    e_mis   = !m_busy && memop && !al;
    e_berr  = m_busy && !dmem_ack && last;
    if (started) begin
      chk_b("pcsrc", pcsrc_M, valid_M && branch_M && zero_M);
      chk_w("pcbranch", pcbranch_out, pcbranch_M);
      chk_b("stall", stall_M, e_stall);
      chk_b("misalign", misalign_M, e_mis);
      chk_b("bus_err", bus_err, e_berr);
      chk_b("req", dmem_req, m_busy);
      if (m_busy) begin
        chk_b("we", dmem_we, m_t.memwrite);
        chk_w("addr", dmem_addr, m_t.alu & ~32'd3);
        chk_w("be", 32'(dmem_be), 32'(model_be(m_t.size, m_t.alu[1:0])));
        chk_w("wdata", dmem_wdata, model_wdata(m_t.size, m_t.wd));
      end
      chk_b("valid_W", valid_W, w_valid);
      chk_b("regwrite_W", regwrite_W, w_regwrite);
      chk_b("memtoreg_W", memtoreg_W, w_memtoreg);
      chk_w("aluresult_W", aluresult_W, w_alu);
      chk_w("readdata_W", readdata_W, w_rd);
      chk_w("writereg_W", 32'(writereg_W), 32'(w_wreg));
      if (dmem_req) begin
        n_req++; last_addr = dmem_addr; last_wdata = dmem_wdata;
        last_be = dmem_be; last_we = dmem_we;
      end
      if (misalign_M) n_mis++;
      if (bus_err) n_berr++;
    end
  end

  // Model state update, just after each edge using the pre-edge inputs.
  always @(posedge clk) begin
    #1;
    m_adv = !e_stall;
    if (reset) begin
      m_busy = 0; m_waited = 0; m_adv = 1; wb_bubble();
    end else if (!m_busy) begin
      if (!(valid_M && (memread_M || memwrite_M))) begin
        w_valid = valid_M; w_regwrite = regwrite_M; w_memtoreg = memtoreg_M;
        w_alu = aluresult_M; w_rd = 0; w_wreg = writereg_M;
      end else begin
        wb_bubble();
        if (!e_mis) begin
          m_busy = 1; m_waited = 0;
          m_t = '{valid: valid_M, zero: zero_M, regwrite: regwrite_M, memtoreg: memtoreg_M,
                  memread: memread_M, memwrite: memwrite_M, branch: branch_M,
                  uns: unsigned_M, size: size_M, alu: aluresult_M, wd: writedata_M,
                  pcb: pcbranch_M, wreg: writereg_M};
        end
      end
    end else if (dmem_ack) begin
      w_valid = 1; w_regwrite = m_t.regwrite; w_memtoreg = m_t.memtoreg;
      w_alu = m_t.alu; w_wreg = m_t.wreg;
      w_rd = m_t.memwrite ? 32'd0 : load_value(dmem_rdata, m_t.alu[1:0], m_t.size, m_t.uns);
      m_busy = 0;
    end else begin
      wb_bubble();
      if (e_berr) m_busy = 0;
      else m_waited++;
    end
  end

  // ---------------- stimulus ----------------
  int cur_lat = 0;
  logic [31:0] cur_rdata = 0;
  logic idle_ack = 0;

  task automatic step();
    @(posedge clk);
    #2;
    dmem_ack   = (m_busy && m_waited == cur_lat) ||
                 (!m_busy && idle_ack && ($urandom_range(3) == 0));
    dmem_rdata = m_busy ? cur_rdata : $urandom;
  endtask

  task automatic drive(input instr_t i);
    valid_M = i.valid; zero_M = i.zero; regwrite_M = i.regwrite; memtoreg_M = i.memtoreg;
    memread_M = i.memread; memwrite_M = i.memwrite; branch_M = i.branch;
    unsigned_M = i.uns; size_M = i.size; aluresult_M = i.alu; writedata_M = i.wd;
    pcbranch_M = i.pcb; writereg_M = i.wreg;
  endtask

  // Present one instruction and hold it until it leaves EX/MEM.
  task automatic run_instr(input instr_t ins, input int lat, input logic [31:0] rd,
                           input int rst_at, output int cycles);
    drive(ins);
    cur_lat = lat; cur_rdata = rd; cycles = 0;
    do begin
      reset = (cycles == rst_at);
      step();
      cycles++;
    end while (!m_adv && cycles < 64);
    reset = 0;
    if (!m_adv) begin
      n_cmp++; n_bad++;
      $display("FAIL advance: instruction still held after %0d cycles, required release", cycles);
    end
    drive('0);
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    i = '0;
    k = $urandom_range(9);
    i.valid = ($urandom_range(7) != 0);
    i.zero = 1'($urandom); i.regwrite = 1'($urandom); i.memtoreg = 1'($urandom);
    i.uns = 1'($urandom); i.size = 2'($urandom);
    i.alu = $urandom; i.wd = $urandom; i.pcb = $urandom; i.wreg = REG_W'($urandom);
    if (k < 4) i.memread = 1;
    else if (k < 7) i.memwrite = 1;
    else if (k == 7) i.branch = 1;
    if ($urandom_range(3) != 0) begin
      if (i.size == 2'd1) i.alu[0] = 1'b0;
      else if (i.size[1]) i.alu[1:0] = 2'b00;
    end
    return i;
  endfunction

  initial begin : stim
    instr_t ins;
    int cyc, b_req, b_mis, b_berr;

    drive('0);
    step();
    started = 1;
    reset = 0;
    chk_b("reset valid_W", valid_W, 1'b0);
    chk_w("reset readdata_W", readdata_W, 32'h0);
    chk_w("reset aluresult_W", aluresult_W, 32'h0);
    chk_b("reset req", dmem_req, 1'b0);
    step();

    // ALU op passes through in one cycle
    ins = '0; ins.valid = 1; ins.alu = 32'h1234; ins.regwrite = 1; ins.wreg = 5'd7;
    run_instr(ins, 0, 0, -1, cyc);
    chk_w("alu cycles", cyc, 1);
    chk_w("alu aluresult_W", aluresult_W, 32'h1234);
    chk_b("alu valid_W", valid_W, 1'b1);
    chk_w("alu writereg_W", 32'(writereg_W), 32'd7);

    // lw 0x100, ack in first ACCESS cycle
    ins = '0; ins.valid = 1; ins.memread = 1; ins.memtoreg = 1; ins.regwrite = 1;
    ins.size = 2'b10; ins.alu = 32'h100; ins.wreg = 5'd3;
    run_instr(ins, 0, 32'hDEAD_BEEF, -1, cyc);
    chk_w("lw cycles", cyc, 2);
    chk_w("lw readdata_W", readdata_W, 32'hDEAD_BEEF);

    // lb / lbu 0x103
    ins.size = 2'b00; ins.alu = 32'h103; ins.uns = 0;
    run_instr(ins, 1, 32'h80FF_FF00, -1, cyc);
    chk_w("lb readdata_W", readdata_W, 32'hFFFF_FF80);
    ins.uns = 1;
    run_instr(ins, 2, 32'h80FF_FF00, -1, cyc);
    chk_w("lbu readdata_W", readdata_W, 32'h0000_0080);

    // sh 0x102, ack after 3 waits (same cycle the timeout would fire)
    ins = '0; ins.valid = 1; ins.memwrite = 1; ins.size = 2'b01; ins.alu = 32'h102;
    ins.wd = 32'h0000_ABCD;
    run_instr(ins, 3, 32'h1111_1111, -1, cyc);
    chk_w("sh cycles", cyc, 5);
    chk_w("sh be", 32'(last_be), 32'hC);
    chk_w("sh wdata", last_wdata, 32'hABCD_ABCD);
    chk_b("sh we", last_we, 1'b1);
    chk_w("sh addr", last_addr, 32'h100);
    chk_b("sh valid_W", valid_W, 1'b1);
    chk_w("sh readdata_W", readdata_W, 32'h0);

    // misaligned lw 0x101
    b_req = n_req; b_mis = n_mis;
    ins = '0; ins.valid = 1; ins.memread = 1; ins.regwrite = 1; ins.size = 2'b10;
    ins.alu = 32'h101;
    run_instr(ins, 0, 0, -1, cyc);
    chk_w("misalign pulses", n_mis - b_mis, 1);
    chk_w("misalign reqs", n_req - b_req, 0);
    chk_b("misalign valid_W", valid_W, 1'b0);

    // timeout: no ack
    b_req = n_req; b_berr = n_berr;
    ins.alu = 32'h200;
    run_instr(ins, 100, 0, -1, cyc);
    chk_w("timeout cycles", cyc, 5);
    chk_w("timeout req cycles", n_req - b_req, 4);
    chk_w("timeout bus_err pulses", n_berr - b_berr, 1);
    chk_b("timeout req dropped", dmem_req, 1'b0);
    chk_b("timeout valid_W", valid_W, 1'b0);

    // reset mid-ACCESS, then a stray ack
    run_instr(ins, 100, 0, 2, cyc);
    chk_b("rst req dropped", dmem_req, 1'b0);
    chk_b("rst valid_W", valid_W, 1'b0);
    dmem_ack = 1;
    step();
    chk_b("post-rst ack valid_W", valid_W, 1'b0);
    chk_b("post-rst ack req", dmem_req, 1'b0);

    // randomized traffic
    idle_ack = 1;
    for (int n = 0; n < 400; n++) begin
      run_instr(rand_instr(), int'($urandom_range(5)), $urandom,
                ($urandom_range(30) == 0) ? int'($urandom_range(3)) : -1, cyc);
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
